// File: rtl/mem_bus_pkg.sv
// ============================================================================
// Module   : mem_bus_pkg
// Purpose  : Shared types and constants for the two-port memory bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY0 = 2'd1,
      ST_BUSY1 = 2'd2
   } state_e;

   typedef struct packed {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   localparam logic [31:0] c_err_rdata = 32'hDEAD_BEEF;

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// Module   : mem_bus_arbiter_if
// Purpose  : Bundles both requester ports and the downstream memory bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_arbiter_if;

   logic        i_m0_valid;
   logic        i_m0_instr;
   logic [31:0] i_m0_addr;
   logic [31:0] i_m0_wdata;
   logic [3:0]  i_m0_wstrb;
   logic        o_m0_ready;
   logic [31:0] o_m0_rdata;

   logic        i_m1_valid;
   logic        i_m1_instr;
   logic [31:0] i_m1_addr;
   logic [31:0] i_m1_wdata;
   logic [3:0]  i_m1_wstrb;
   logic        o_m1_ready;
   logic [31:0] o_m1_rdata;

   logic        o_mem_valid;
   logic        o_mem_instr;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_wstrb;
   logic        i_mem_ready;
   logic [31:0] i_mem_rdata;

   logic [1:0]  o_grant;
   logic        o_timeout;

   // Arbiter side
   modport slave (
      input  i_m0_valid, i_m0_instr, i_m0_addr, i_m0_wdata, i_m0_wstrb,
      output o_m0_ready, o_m0_rdata,
      input  i_m1_valid, i_m1_instr, i_m1_addr, i_m1_wdata, i_m1_wstrb,
      output o_m1_ready, o_m1_rdata,
      output o_mem_valid, o_mem_instr, o_mem_addr, o_mem_wdata, o_mem_wstrb,
      input  i_mem_ready, i_mem_rdata,
      output o_grant, o_timeout
   );

   // Requester / memory side
   modport master (
      output i_m0_valid, i_m0_instr, i_m0_addr, i_m0_wdata, i_m0_wstrb,
      input  o_m0_ready, o_m0_rdata,
      output i_m1_valid, i_m1_instr, i_m1_addr, i_m1_wdata, i_m1_wstrb,
      input  o_m1_ready, o_m1_rdata,
      input  o_mem_valid, o_mem_instr, o_mem_addr, o_mem_wdata, o_mem_wstrb,
      output i_mem_ready, i_mem_rdata,
      input  o_grant, o_timeout
   );

endinterface

`default_nettype wire

// File: rtl/mem_bus_rr_pick.sv
// ============================================================================
// Module   : mem_bus_rr_pick
// Purpose  : Two-input one-hot picker, round-robin or port-0 fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_rr_pick #(
   parameter int PRIORITY_MODE = 0
) (
   input  logic [1:0] i_req,
   input  logic       i_last_served,   // 1 = port 1 was served last
   output logic [1:0] o_grant
);

   always_comb begin
      o_grant = i_req;
      if (i_req == 2'b11) begin
         if ((PRIORITY_MODE != 0) || i_last_served) begin
            o_grant = 2'b01;
         end else begin
            o_grant = 2'b10;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one native valid/ready memory bus between two requesters,
//            with grant locking and a stall watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int          PRIORITY_MODE  = 0,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERR_RDATA      = c_err_rdata
) (
   input  logic              i_clk,
   input  logic              i_resetn,
   mem_bus_arbiter_if.slave  bus
);

   localparam int c_wdog_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [c_wdog_w-1:0] c_wdog_max = c_wdog_w'(TIMEOUT_CYCLES);

   state_e                state_q, state_d;
   req_t                  mem_req_q, mem_req_d;
   logic                  last_served_q, last_served_d;
   logic [c_wdog_w-1:0]   wdog_q, wdog_d;
   logic                  timeout_q, timeout_d;

   req_t                  w_req0, w_req1;
   logic [1:0]            w_pick;
   logic                  w_busy, w_expire, w_done;
   logic                  w_m0_ready, w_m1_ready;
   logic [31:0]           w_rdata;

   assign w_req0 = '{instr: bus.i_m0_instr, addr: bus.i_m0_addr,
                     wdata: bus.i_m0_wdata, wstrb: bus.i_m0_wstrb};
   assign w_req1 = '{instr: bus.i_m1_instr, addr: bus.i_m1_addr,
                     wdata: bus.i_m1_wdata, wstrb: bus.i_m1_wstrb};

   mem_bus_rr_pick #(
      .PRIORITY_MODE (PRIORITY_MODE)
   ) u_pick (
      .i_req         ({bus.i_m1_valid, bus.i_m0_valid}),
      .i_last_served (last_served_q),
      .o_grant       (w_pick)
   );

   // The watchdog saturates at TIMEOUT_CYCLES; that cycle is the forced completion.
   assign w_busy     = (state_q != ST_IDLE);
   assign w_expire   = (TIMEOUT_CYCLES != 0) && w_busy && !bus.i_mem_ready && (wdog_q == c_wdog_max);
   assign w_done     = w_busy && (bus.i_mem_ready || w_expire);
   assign w_rdata    = bus.i_mem_ready ? bus.i_mem_rdata : ERR_RDATA;
   assign w_m0_ready = (state_q == ST_BUSY0) && w_done;
   assign w_m1_ready = (state_q == ST_BUSY1) && w_done;

   always_comb begin
      state_d       = state_q;
      mem_req_d     = mem_req_q;
      last_served_d = last_served_q;
      wdog_d        = wdog_q;
      timeout_d     = timeout_q;
      case (state_q)
         ST_IDLE: begin
            wdog_d = '0;
            if (w_pick[0]) begin
               state_d   = ST_BUSY0;
               mem_req_d = w_req0;
            end else if (w_pick[1]) begin
               state_d   = ST_BUSY1;
               mem_req_d = w_req1;
            end
         end
         ST_BUSY0, ST_BUSY1: begin
            if (w_done) begin
               state_d       = ST_IDLE;
               last_served_d = (state_q == ST_BUSY1);
               wdog_d        = '0;
               timeout_d     = timeout_q | w_expire;
            end else if (wdog_q != c_wdog_max) begin
               wdog_d = wdog_q + c_wdog_w'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state_q       <= ST_IDLE;
         mem_req_q     <= '0;
         last_served_q <= 1'b1;
         wdog_q        <= '0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_req_q     <= mem_req_d;
         last_served_q <= last_served_d;
         wdog_q        <= wdog_d;
         timeout_q     <= timeout_d;
      end
   end

   assign bus.o_mem_valid = w_busy;
   assign bus.o_mem_instr = mem_req_q.instr;
   assign bus.o_mem_addr  = mem_req_q.addr;
   assign bus.o_mem_wdata = mem_req_q.wdata;
   assign bus.o_mem_wstrb = mem_req_q.wstrb;
   assign bus.o_grant     = {state_q == ST_BUSY1, state_q == ST_BUSY0};
   assign bus.o_timeout   = timeout_q;
   assign bus.o_m0_ready  = w_m0_ready;
   assign bus.o_m1_ready  = w_m1_ready;
   assign bus.o_m0_rdata  = w_m0_ready ? w_rdata : 32'h0;
   assign bus.o_m1_rdata  = w_m1_ready ? w_rdata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Scoreboard bench for mem_bus_arbiter with random and directed traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;
   import mem_bus_pkg::*;

   localparam int TMO = 8;

   typedef struct {
      logic [31:0] rdata;
      int          cycles;
   } exp_t;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   mem_bus_arbiter_if bus ();
   mem_bus_arbiter_if bus_p ();

   mem_bus_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(TMO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
      .i_clk    (clk),
      .i_resetn (resetn),
      .bus      (bus)
   );

   mem_bus_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(TMO), .ERR_RDATA(32'hDEAD_BEEF)) dut_p (
      .i_clk    (clk),
      .i_resetn (resetn),
      .bus      (bus_p)
   );

   // Zero-wait memory for the fixed-priority instance
   assign bus_p.i_mem_ready = bus_p.o_mem_valid;
   assign bus_p.i_mem_rdata = bus_p.o_mem_addr ^ 32'hFFFF_0000;

   int   checks = 0;
   int   passes = 0;
   exp_t q0[$];
   exp_t q1[$];
   req_t pend0[$];
   req_t pend1[$];
   bit   busy0 = 1'b0;
   bit   busy1 = 1'b0;
   int   gnt_log[$];

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Downstream memory: latency and contents are a function of the address
   function automatic int lat_of(input logic [31:0] a);
      if (a == 32'h1000_0000) return 5;
      if (a == 32'h0000_0100) return 1;
      if (a[11:8] == 4'hF)    return 99;
      return int'(a[4:2]);
   endfunction

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h1234_5678;
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   function automatic exp_t model(input req_t r);
      exp_t e;
      int   lat = lat_of(r.addr);
      if (lat + 1 <= TMO) begin
         e.rdata  = mem_data(r.addr);
         e.cycles = lat + 1;
      end else begin
         e.rdata  = 32'hDEAD_BEEF;
         e.cycles = TMO + 1;
      end
      return e;
   endfunction

   function automatic req_t mk(input logic instr, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s);
      req_t r;
      r.instr = instr; r.addr = a; r.wdata = d; r.wstrb = s;
      return r;
   endfunction

   function automatic req_t port_req(input int p);
      if (p == 0) return mk(bus.i_m0_instr, bus.i_m0_addr, bus.i_m0_wdata, bus.i_m0_wstrb);
      return mk(bus.i_m1_instr, bus.i_m1_addr, bus.i_m1_wdata, bus.i_m1_wstrb);
   endfunction

   task automatic drive(input int p, input logic v, input req_t r);
      if (p == 0) begin
         bus.i_m0_valid = v; bus.i_m0_instr = r.instr; bus.i_m0_addr = r.addr;
         bus.i_m0_wdata = r.wdata; bus.i_m0_wstrb = r.wstrb;
      end else begin
         bus.i_m1_valid = v; bus.i_m1_instr = r.instr; bus.i_m1_addr = r.addr;
         bus.i_m1_wdata = r.wdata; bus.i_m1_wstrb = r.wstrb;
      end
   endtask

   // Requester: holds each request until its ready pulse, back-to-back if more are queued
   task automatic run_port(input int p);
      req_t r;
      bit   got;
      forever begin
         @(posedge clk); #1;
         if ((p == 0) ? (pend0.size() != 0) : (pend1.size() != 0)) begin
            if (p == 0) begin r = pend0.pop_front(); busy0 = 1'b1; q0.push_back(model(r)); end
            else        begin r = pend1.pop_front(); busy1 = 1'b1; q1.push_back(model(r)); end
            drive(p, 1'b1, r);
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
               @(negedge clk);
               if (!resetn) got = 1'b1;
               else got = (p == 0) ? bus.o_m0_ready : bus.o_m1_ready;
            end
            if (!got) begin
               if (p == 0) check("m0_ready_wait", 0, 1);
               else        check("m1_ready_wait", 0, 1);
            end
         end else begin
            drive(p, 1'b0, '0);
            if (p == 0) busy0 = 1'b0; else busy1 = 1'b0;
         end
      end
   endtask

   initial run_port(0);
   initial run_port(1);

   initial begin : responder
      int cyc;
      cyc = 0;
      bus.i_mem_ready = 1'b0;
      bus.i_mem_rdata = 32'h0;
      forever begin
         @(posedge clk); #1;
         if (bus.o_mem_valid && resetn) cyc++; else cyc = 0;
         if (bus.o_mem_valid && resetn && (cyc == lat_of(bus.o_mem_addr) + 1)) begin
            bus.i_mem_ready = 1'b1;
            bus.i_mem_rdata = mem_data(bus.o_mem_addr);
         end else begin
            bus.i_mem_ready = 1'b0;
            bus.i_mem_rdata = $urandom;
         end
      end
   end

   initial begin : monitor
      int   cyc;
      int   owner;
      bit   saw_to;
      req_t snap;
      exp_t e;
      cyc = 0; saw_to = 1'b0; owner = 0; snap = '0;
      forever begin
         @(negedge clk);
         if (!resetn) begin cyc = 0; saw_to = 1'b0; continue; end
         check("timeout_sticky", bus.o_timeout, saw_to);
         if (!bus.o_m0_ready) check("m0_rdata_zero", bus.o_m0_rdata, 0);
         if (!bus.o_m1_ready) check("m1_rdata_zero", bus.o_m1_rdata, 0);
         if (!bus.o_mem_valid) begin
            cyc = 0;
            check("idle_outputs", {bus.o_grant, bus.o_m0_ready, bus.o_m1_ready}, 0);
         end else begin
            cyc++;
            check("grant_onehot", $onehot(bus.o_grant), 1);
            if (cyc == 1) begin
               owner = (bus.o_grant == 2'b10) ? 1 : 0;
               gnt_log.push_back(owner);
               snap = port_req(owner);
               check("owner_valid", (owner == 0) ? bus.i_m0_valid : bus.i_m1_valid, 1);
            end
            check("mem_req", {bus.o_mem_instr, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_wstrb}, snap);
            check("other_ready_low", (owner == 0) ? bus.o_m1_ready : bus.o_m0_ready, 0);
            if (bus.o_m0_ready) begin
               if (q0.size() == 0) check("m0_unexpected_ready", 1, 0);
               else begin
                  e = q0.pop_front();
                  check("m0_rdata", bus.o_m0_rdata, e.rdata);
                  check("m0_latency", cyc, e.cycles);
                  if (e.cycles == TMO + 1) saw_to = 1'b1;
               end
            end
            if (bus.o_m1_ready) begin
               if (q1.size() == 0) check("m1_unexpected_ready", 1, 0);
               else begin
                  e = q1.pop_front();
                  check("m1_rdata", bus.o_m1_rdata, e.rdata);
                  check("m1_latency", cyc, e.cycles);
                  if (e.cycles == TMO + 1) saw_to = 1'b1;
               end
            end
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (pend0.size() == 0 && pend1.size() == 0 && !busy0 && !busy1) begin
            check("m0_leftover", q0.size(), 0);
            check("m1_leftover", q1.size(), 0);
            return;
         end
      end
      check("drain_timeout", 0, 1);
   endtask

   task automatic check_order(input string name, input int exp_o[4]);
      check({name, "_count"}, gnt_log.size(), 4);
      for (int i = 0; i < 4 && i < gnt_log.size(); i++) check(name, gnt_log[i], exp_o[i]);
   endtask

   task automatic test_prio();
      int  owners[$];
      int  exp_o[4];
      int  n0;
      bit  done;
      exp_o = '{0, 0, 0, 1};
      n0 = 0; done = 1'b0;
      @(posedge clk); #1;
      bus_p.i_m0_valid = 1'b1; bus_p.i_m0_addr = 32'h40;
      bus_p.i_m1_valid = 1'b1; bus_p.i_m1_addr = 32'h80;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (bus_p.o_m0_ready) begin
            owners.push_back(0);
            check("p_m0_rdata", bus_p.o_m0_rdata, 32'hFFFF_0040);
            n0++;
         end
         if (bus_p.o_m1_ready) begin
            owners.push_back(1);
            check("p_m1_rdata", bus_p.o_m1_rdata, 32'hFFFF_0080);
            done = 1'b1;
         end
         if (bus_p.o_m0_ready && n0 == 3) begin
            @(posedge clk); #1;
            bus_p.i_m0_valid = 1'b0;
         end
      end
      @(posedge clk); #1;
      bus_p.i_m1_valid = 1'b0;
      check("prio_count", owners.size(), 4);
      for (int i = 0; i < 4 && i < owners.size(); i++) check("prio_order", owners[i], exp_o[i]);
   endtask

   initial begin : main
      req_t r;
      int   p;
      int   alt[4];
      alt = '{0, 1, 0, 1};
      bus.i_m0_valid = 1'b0; bus.i_m0_instr = 1'b0; bus.i_m0_addr = '0; bus.i_m0_wdata = '0; bus.i_m0_wstrb = '0;
      bus.i_m1_valid = 1'b0; bus.i_m1_instr = 1'b0; bus.i_m1_addr = '0; bus.i_m1_wdata = '0; bus.i_m1_wstrb = '0;
      bus_p.i_m0_valid = 1'b0; bus_p.i_m0_instr = 1'b0; bus_p.i_m0_addr = '0; bus_p.i_m0_wdata = '0; bus_p.i_m0_wstrb = '0;
      bus_p.i_m1_valid = 1'b0; bus_p.i_m1_instr = 1'b0; bus_p.i_m1_addr = '0; bus_p.i_m1_wdata = '0; bus_p.i_m1_wstrb = '0;

      repeat (3) @(negedge clk);
      check("rst_outputs", {bus.o_mem_valid, bus.o_grant, bus.o_timeout, bus.o_m0_ready, bus.o_m1_ready,
                            bus.o_mem_addr, bus.o_mem_wstrb, bus.o_mem_instr}, 0);
      resetn = 1'b1;

      // Simultaneous requests straight out of reset alternate m0, m1, m0, m1
      gnt_log.delete();
      pend0.push_back(mk(1'b1, 32'h0000_0204, 32'h0, 4'h0));
      pend0.push_back(mk(1'b1, 32'h0000_0208, 32'h0, 4'h0));
      pend1.push_back(mk(1'b0, 32'h0000_0310, 32'h11, 4'hF));
      pend1.push_back(mk(1'b0, 32'h0000_0300, 32'h0, 4'h0));
      drain();
      check_order("rr_order", alt);

      // m0 read of 0x100, then m1 console write with a 5-cycle stall
      pend0.push_back(mk(1'b0, 32'h0000_0100, 32'h0, 4'h0));
      drain();
      pend1.push_back(mk(1'b0, 32'h1000_0000, 32'h41, 4'b0001));
      drain();
      check("timeout_before", bus.o_timeout, 0);

      // Stalled m0 read is force-completed by the watchdog
      pend0.push_back(mk(1'b0, 32'h0000_0F00, 32'h0, 4'h0));
      drain();
      check("timeout_after", bus.o_timeout, 1);

      for (int i = 0; i < 40; i++) begin
         p = $urandom_range(0, 1);
         r.instr = 1'($urandom_range(0, 1));
         r.addr  = $urandom;
         r.addr[1:0] = 2'b00;
         if ($urandom_range(0, 9) == 0) r.addr[11:8] = 4'hF;
         else if (r.addr[11:8] == 4'hF) r.addr[11:8] = 4'h0;
         r.wdata = $urandom;
         r.wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         if (p == 0) pend0.push_back(r); else pend1.push_back(r);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
      end
      drain();
      check("timeout_sticky_end", bus.o_timeout, 1);

      test_prio();

      // Reset in the third BUSY1 cycle abandons the transfer
      pend1.push_back(mk(1'b0, 32'h0000_001C, 32'h0, 4'h0));
      begin : wait_grant
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.o_mem_valid;
         end
         check("rst_test_grant", seen, 1);
      end
      @(posedge clk); @(posedge clk); #3;
      resetn = 1'b0;
      #1;
      check("rst_busy_drop", {bus.o_mem_valid, bus.o_grant, bus.o_m1_ready, bus.o_timeout}, 0);
      q1.delete();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      gnt_log.delete();
      pend0.push_back(mk(1'b0, 32'h0000_0400, 32'h0, 4'h0));
      pend1.push_back(mk(1'b0, 32'h0000_0500, 32'h0, 4'h0));
      drain();
      check("post_rst_count", gnt_log.size(), 2);
      if (gnt_log.size() >= 2) begin
         check("post_rst_first", gnt_log[0], 0);
         check("post_rst_second", gnt_log[1], 1);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, got %0d/%0d", passes, checks);
      $fatal(1);
   end

endmodule

`default_nettype wire
